// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: in-order FIFO of {pc, inst} beats with valid/ready on both sides,
// synchronous flush, and a NOP bubble on the outputs whenever the head is not valid.
module if_id_queue #(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              pc_in,
    input  logic [31:0]              inst_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [63:0]              pc_out,
    output logic [31:0]              inst_out,
    output logic                     misalign_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           push;
    logic           pop;
    entry_t         head;

    // Handshake status comes only from registered occupancy, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (count != CW'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Storage, pointers and occupancy; flush overrides both push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            rptr  <= wptr;
        end else begin
            if (push) begin
                mem[wptr] <= '{pc: pc_in, inst: inst_in, misalign: (pc_in[1:0] != 2'b00)};
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation; storage is masked whenever nothing valid is held.
    always_comb begin
        head         = mem[rptr];
        pc_out       = '0;
        inst_out     = NOP;
        misalign_out = 1'b0;
        if (out_valid) begin
            pc_out       = head.pc;
            inst_out     = head.inst;
            misalign_out = head.misalign;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue (DEPTH=2) with hand-written async reset sequence.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [63:0] pc_in;
    logic [31:0] inst_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] pc_out;
    logic [31:0] inst_out;
    logic        misalign_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_queue #(.DEPTH(2), .NOP(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .inst_in      (inst_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .pc_out       (pc_out),
        .inst_out     (inst_out),
        .misalign_out (misalign_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic [63:0] epc;
        logic [31:0] einst;
        logic        mis;
        logic        irdy;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic r, logic iv, logic [63:0] pc, logic [31:0] inst,
                                logic fl, logic ordy, logic ov, logic [63:0] epc,
                                logic [31:0] einst, logic mis, logic irdy, logic [1:0] cnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.pc = pc; v.inst = inst; v.fl = fl; v.ordy = ordy;
        v.ov = ov; v.epc = epc; v.einst = einst; v.mis = mis; v.irdy = irdy; v.cnt = cnt;
        vq.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(int idx, logic ov, logic [63:0] epc, logic [31:0] einst,
                             logic mis, logic irdy, logic [1:0] cnt);
        check("out_valid",    idx, 64'(out_valid),    64'(ov));
        check("pc_out",       idx, pc_out,            epc);
        check("inst_out",     idx, 64'(inst_out),     64'(einst));
        check("misalign_out", idx, 64'(misalign_out), 64'(mis));
        check("in_ready",     idx, 64'(in_ready),     64'(irdy));
        check("count",        idx, 64'(count),        64'(cnt));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; pc_in = '0; inst_in = '0; flush = 1'b0; out_ready = 1'b0;

        //   rst iv pc        inst          fl ordy | ov pc_out   inst_out      mis irdy cnt
        // reset then idle
        add(0, 0, 64'h0,   32'h0,        0, 0,     0, 64'h0,   NOP,          0, 1, 0);
        add(0, 0, 64'h0,   32'h0,        0, 0,     0, 64'h0,   NOP,          0, 1, 0);
        add(0, 0, 64'h0,   32'h0,        0, 0,     0, 64'h0,   NOP,          0, 1, 0);
        // streaming with decode always ready
        add(1, 1, 64'h0,   32'h00100093, 0, 1,     1, 64'h0,   32'h00100093, 0, 1, 1);
        add(1, 1, 64'h4,   32'h00100094, 0, 1,     1, 64'h4,   32'h00100094, 0, 1, 1);
        add(1, 1, 64'h8,   32'h00100095, 0, 1,     1, 64'h8,   32'h00100095, 0, 1, 1);
        add(1, 1, 64'hC,   32'h00100096, 0, 1,     1, 64'hC,   32'h00100096, 0, 1, 1);
        add(1, 0, 64'h0,   32'h0,        0, 1,     0, 64'h0,   NOP,          0, 1, 0);
        // stall until full; third beat refused, including on the pop cycle
        add(1, 1, 64'h100, 32'h00200113, 0, 0,     1, 64'h100, 32'h00200113, 0, 1, 1);
        add(1, 1, 64'h104, 32'h00300193, 0, 0,     1, 64'h100, 32'h00200113, 0, 0, 2);
        add(1, 1, 64'h108, 32'h00400213, 0, 0,     1, 64'h100, 32'h00200113, 0, 0, 2);
        add(1, 1, 64'h108, 32'h00400213, 0, 1,     1, 64'h104, 32'h00300193, 0, 1, 1);
        add(1, 1, 64'h108, 32'h00400213, 0, 1,     1, 64'h108, 32'h00400213, 0, 1, 1);
        add(1, 0, 64'h0,   32'h0,        0, 1,     0, 64'h0,   NOP,          0, 1, 0);
        // push+pop at count=1 across pointer wrap
        add(1, 1, 64'h200, 32'hA0000001, 0, 0,     1, 64'h200, 32'hA0000001, 0, 1, 1);
        add(1, 1, 64'h204, 32'hA0000002, 0, 1,     1, 64'h204, 32'hA0000002, 0, 1, 1);
        add(1, 1, 64'h208, 32'hA0000003, 0, 1,     1, 64'h208, 32'hA0000003, 0, 1, 1);
        add(1, 1, 64'h20C, 32'hA0000004, 0, 1,     1, 64'h20C, 32'hA0000004, 0, 1, 1);
        add(1, 0, 64'h0,   32'h0,        0, 1,     0, 64'h0,   NOP,          0, 1, 0);
        // flush while full and while an acceptable beat is offered
        add(1, 1, 64'h300, 32'hB0000001, 0, 0,     1, 64'h300, 32'hB0000001, 0, 1, 1);
        add(1, 1, 64'h304, 32'hB0000002, 0, 0,     1, 64'h300, 32'hB0000001, 0, 0, 2);
        add(1, 1, 64'h308, 32'hB0000003, 1, 0,     0, 64'h0,   NOP,          0, 1, 0);
        add(1, 1, 64'h30C, 32'hB0000004, 1, 1,     0, 64'h0,   NOP,          0, 1, 0);
        add(1, 0, 64'h0,   32'h0,        0, 1,     0, 64'h0,   NOP,          0, 1, 0);
        // misaligned head, then fill for the async reset sequence
        add(1, 1, 64'h102, 32'hC0000001, 0, 0,     1, 64'h102, 32'hC0000001, 1, 1, 1);
        add(1, 1, 64'h108, 32'hC0000002, 0, 0,     1, 64'h102, 32'hC0000001, 1, 0, 2);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; in_valid = vq[i].iv; pc_in = vq[i].pc; inst_in = vq[i].inst;
            flush = vq[i].fl; out_ready = vq[i].ordy;
            @(posedge clk);
            #1;
            check_all(i, vq[i].ov, vq[i].epc, vq[i].einst, vq[i].mis, vq[i].irdy, vq[i].cnt);
        end

        // async reset between edges with count=2: outputs clear before any clock edge
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all(100, 1'b0, 64'h0, NOP, 1'b0, 1'b1, 2'd0);

        // after release the queue works again from empty
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; pc_in = 64'h400; inst_in = 32'hD0000001; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_all(101, 1'b1, 64'h400, 32'hD0000001, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_all(102, 1'b0, 64'h0, NOP, 1'b0, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
